// File: rtl/multi_edge_event_det_if.sv
// Event offer port: the detector offers a channel index, the consumer accepts it.
interface multi_edge_event_det_if #(
  parameter int ID_W = 2
);
  logic            evt_valid;
  logic [ID_W-1:0] evt_id;
  logic            evt_ready;

  modport master (
    output evt_valid,
    output evt_id,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    output evt_ready
  );
endinterface

// File: rtl/multi_edge_event_det.sv
// Multi-channel edge detector with optional synchronisers, sticky pending/overflow
// flags and a valid/ready port reporting the lowest pending channel.
//
// state    | meaning
// ST_IDLE  | no offer outstanding; picks the lowest pending channel
// ST_OFFER | evt_id offered and held until the consumer accepts it
module multi_edge_event_det #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  localparam int ID_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  aclk_i,
  input  logic                  areset_i,
  input  logic [NUM_CH-1:0]     sig_in_i,
  input  logic [2*NUM_CH-1:0]   edge_mode_i,
  input  logic [NUM_CH-1:0]     ovf_clr_i,
  output logic [NUM_CH-1:0]     edge_pulse_o,
  output logic [NUM_CH-1:0]     pend_o,
  output logic [NUM_CH-1:0]     ovf_o,
  multi_edge_event_det_if.master evt_if
);

  typedef enum logic {ST_IDLE, ST_OFFER} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   evt_id_q, evt_id_d, lowest;
  logic [NUM_CH-1:0] samp, prev_q, det, acc;
  logic [NUM_CH-1:0] pulse_q, pend_q, pend_d, ovf_q, ovf_d;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign samp = sig_in_i;
    end else begin : g_sync
      logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge aclk_i) begin
        if (areset_i) begin
          for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
          sync_q[0] <= sig_in_i;
          for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
      end
      assign samp = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  always_comb begin
    det = '0;
    acc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      det[i] = (edge_mode_i[2*i]   &  samp[i] & ~prev_q[i]) |
               (edge_mode_i[2*i+1] & ~samp[i] &  prev_q[i]);
      acc[i] = (state_q == ST_OFFER) && evt_if.evt_ready && (evt_id_q == ID_W'(i));
    end
  end

  // A new edge beats a same-cycle accept, so the channel stays pending without overflowing.
  always_comb begin
    pend_d = (pend_q & ~acc) | det;
    ovf_d  = (ovf_q & ~ovf_clr_i) | (det & pend_q & ~acc);
  end

  always_comb begin
    lowest = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend_q[i]) lowest = ID_W'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    evt_id_d = evt_id_q;
    case (state_q)
      ST_IDLE: begin
        if (|pend_q) begin
          state_d  = ST_OFFER;
          evt_id_d = lowest;
        end
      end
      ST_OFFER: begin
        if (evt_if.evt_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      state_q  <= ST_IDLE;
      evt_id_q <= '0;
      prev_q   <= '0;
      pulse_q  <= '0;
      pend_q   <= '0;
      ovf_q    <= '0;
    end else begin
      state_q  <= state_d;
      evt_id_q <= evt_id_d;
      prev_q   <= samp;
      pulse_q  <= det;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
    end
  end

  assign edge_pulse_o     = pulse_q;
  assign pend_o           = pend_q;
  assign ovf_o            = ovf_q;
  assign evt_if.evt_valid = (state_q == ST_OFFER);
  assign evt_if.evt_id    = evt_id_q;

endmodule

// File: tb/tb_multi_edge_event_det.sv
// Bench for multi_edge_event_det: directed vector table, corner-case sequences,
// then random traffic against a delay-line reference model.
module tb_multi_edge_event_det;
  localparam int NUM_CH = 4;
  localparam int SYNC   = 2;
  localparam int ID_W   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] sig, clr;
  logic [7:0]        mode;
  logic              ready;
  logic [NUM_CH-1:0] pulse, pend, ovf;

  int checks   = 0;
  int failures = 0;

  multi_edge_event_det_if #(.ID_W(ID_W)) evt_if ();
  assign evt_if.evt_ready = ready;

  multi_edge_event_det #(.NUM_CH(NUM_CH), .SYNC_STAGES(SYNC)) dut (
    .aclk_i       (clk),
    .areset_i     (rst),
    .sig_in_i     (sig),
    .edge_mode_i  (mode),
    .ovf_clr_i    (clr),
    .edge_pulse_o (pulse),
    .pend_o       (pend),
    .ovf_o        (ovf),
    .evt_if       (evt_if.master)
  );

  always #5 clk = ~clk;

  // Reference model: inputs pass through a delay line; samp/prev are taps on it.
  logic [NUM_CH-1:0] h [SYNC+2];
  logic [NUM_CH-1:0] m_pulse, m_pend, m_ovf;
  logic              m_valid;
  int                m_id;

  task automatic model_step();
    logic [NUM_CH-1:0] s, p, det, acc, old_pend;
    if (rst) begin
      for (int i = 0; i < SYNC + 2; i++) h[i] = '0;
      m_pulse = '0; m_pend = '0; m_ovf = '0; m_valid = 1'b0; m_id = 0;
      return;
    end
    for (int i = SYNC + 1; i > 0; i--) h[i] = h[i-1];
    h[0] = sig;
    s = h[SYNC];
    p = h[SYNC+1];
    det = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      case (mode[2*c +: 2])
        2'b01:   det[c] = s[c] && !p[c];
        2'b10:   det[c] = !s[c] && p[c];
        2'b11:   det[c] = s[c] != p[c];
        default: det[c] = 1'b0;
      endcase
    end
    acc = '0;
    if (m_valid && ready) acc[m_id] = 1'b1;
    old_pend = m_pend;
    m_pend   = (m_pend & ~acc) | det;
    m_ovf    = (m_ovf & ~clr) | (det & old_pend & ~acc);
    m_pulse  = det;
    if (m_valid) begin
      if (ready) m_valid = 1'b0;
    end else if (old_pend != '0) begin
      m_valid = 1'b1;
      for (int c = NUM_CH - 1; c >= 0; c--) if (old_pend[c]) m_id = c;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model_pulse", 32'(pulse), 32'(m_pulse));
    chk("model_pend",  32'(pend),  32'(m_pend));
    chk("model_ovf",   32'(ovf),   32'(m_ovf));
    chk("model_valid", 32'(evt_if.evt_valid), 32'(m_valid));
    chk("model_id",    32'(evt_if.evt_id),    32'(m_id));
  endtask

  task automatic do_reset();
    sig = '0; clr = '0; ready = 1'b0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic              rst;
    logic [NUM_CH-1:0] sig;
    logic [7:0]        mode;
    logic              ready;
    logic [NUM_CH-1:0] pulse;
    logic [NUM_CH-1:0] pend;
    logic              valid;
    logic [ID_W-1:0]   id;
  } vec_t;

  vec_t vec [17];
  int   pcount, pidx;

  initial begin
    rst = 1'b1; sig = '0; clr = '0; ready = 1'b0; mode = 8'b0000_0001;

    // ch0 rise latency, accept, ignored fall; then ch1 both-edges pulses 3 cycles apart
    vec[0]  = '{1'b1, 4'b0000, 8'b0000_0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vec[1]  = '{1'b0, 4'b0001, 8'b0000_0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vec[2]  = '{1'b0, 4'b0001, 8'b0000_0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vec[3]  = '{1'b0, 4'b0001, 8'b0000_0001, 1'b0, 4'b0001, 4'b0001, 1'b0, 2'd0};
    vec[4]  = '{1'b0, 4'b0001, 8'b0000_0001, 1'b0, 4'b0000, 4'b0001, 1'b1, 2'd0};
    vec[5]  = '{1'b0, 4'b0001, 8'b0000_0001, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vec[6]  = '{1'b0, 4'b0000, 8'b0000_0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vec[7]  = '{1'b0, 4'b0000, 8'b0000_0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vec[8]  = '{1'b0, 4'b0000, 8'b0000_0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vec[9]  = '{1'b0, 4'b0010, 8'b0000_1101, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vec[10] = '{1'b0, 4'b0010, 8'b0000_1101, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vec[11] = '{1'b0, 4'b0010, 8'b0000_1101, 1'b0, 4'b0010, 4'b0010, 1'b0, 2'd0};
    vec[12] = '{1'b0, 4'b0000, 8'b0000_1101, 1'b0, 4'b0000, 4'b0010, 1'b1, 2'd1};
    vec[13] = '{1'b0, 4'b0000, 8'b0000_1101, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd1};
    vec[14] = '{1'b0, 4'b0000, 8'b0000_1101, 1'b0, 4'b0010, 4'b0010, 1'b0, 2'd1};
    vec[15] = '{1'b0, 4'b0000, 8'b0000_1101, 1'b0, 4'b0000, 4'b0010, 1'b1, 2'd1};
    vec[16] = '{1'b0, 4'b0000, 8'b0000_1101, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd1};

    for (int i = 0; i < 17; i++) begin
      rst = vec[i].rst; sig = vec[i].sig; mode = vec[i].mode; ready = vec[i].ready;
      tick();
      chk($sformatf("vec%0d_pulse", i), 32'(pulse), 32'(vec[i].pulse));
      chk($sformatf("vec%0d_pend", i),  32'(pend),  32'(vec[i].pend));
      chk($sformatf("vec%0d_ovf", i),   32'(ovf),   32'(0));
      chk($sformatf("vec%0d_valid", i), 32'(evt_if.evt_valid), 32'(vec[i].valid));
      chk($sformatf("vec%0d_id", i),    32'(evt_if.evt_id),    32'(vec[i].id));
    end

    // ch3 and ch1 together, then ch0: offer stays on 1, then 0, then 3
    do_reset();
    mode = 8'b01_00_01_01; sig = 4'b1010;
    tick(); tick(); tick();
    chk("t3_pend_13", 32'(pend), 32'(4'b1010));
    tick();
    chk("t3_first_id", 32'(evt_if.evt_id), 32'(1));
    sig = 4'b1011;
    tick(); tick(); tick();
    chk("t3_pend_all", 32'(pend), 32'(4'b1011));
    chk("t3_id_held", 32'(evt_if.evt_id), 32'(1));
    ready = 1'b1; tick(); ready = 1'b0;
    chk("t3_bubble", 32'(evt_if.evt_valid), 32'(0));
    tick();
    chk("t3_second_id", 32'(evt_if.evt_id), 32'(0));
    ready = 1'b1; tick(); ready = 1'b0; tick();
    chk("t3_third_id", 32'(evt_if.evt_id), 32'(3));
    chk("t3_third_valid", 32'(evt_if.evt_valid), 32'(1));
    ready = 1'b1; tick(); ready = 1'b0;

    // ch2 overflow, clear, and clear coincident with a new overflow
    do_reset();
    mode = 8'b00_01_00_00; sig = 4'b0100;
    tick(); tick(); tick();
    sig = 4'b0000; tick(); tick();
    sig = 4'b0100; tick(); tick(); tick();
    chk("t4_ovf_set", 32'(ovf[2]), 32'(1));
    chk("t4_pend_set", 32'(pend[2]), 32'(1));
    clr = 4'b0100; tick(); clr = '0;
    chk("t4_ovf_clr", 32'(ovf[2]), 32'(0));
    sig = 4'b0000; tick(); tick();
    sig = 4'b0100; tick(); tick();
    clr = 4'b0100; tick(); clr = '0;
    chk("t4_set_beats_clr", 32'(ovf[2]), 32'(1));

    // ch1 edge in the same cycle as its accept
    do_reset();
    mode = 8'b00_00_11_00; sig = 4'b0010;
    tick(); tick(); tick(); tick();
    chk("t5_offer_id", 32'(evt_if.evt_id), 32'(1));
    sig = 4'b0000; tick(); tick();
    ready = 1'b1; tick(); ready = 1'b0;
    chk("t5_pend_kept", 32'(pend[1]), 32'(1));
    chk("t5_no_ovf", 32'(ovf[1]), 32'(0));
    chk("t5_idle", 32'(evt_if.evt_valid), 32'(0));
    tick();
    chk("t5_reoffer", 32'(evt_if.evt_valid), 32'(1));
    ready = 1'b1; tick(); ready = 1'b0;

    // reset mid-offer, input held high across reset
    do_reset();
    mode = 8'b00_00_00_01; sig = 4'b0001;
    tick(); tick(); tick(); tick();
    chk("t6_offering", 32'(evt_if.evt_valid), 32'(1));
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_rst_valid", 32'(evt_if.evt_valid), 32'(0));
    chk("t6_rst_pend",  32'(pend), 32'(0));
    chk("t6_rst_pulse", 32'(pulse), 32'(0));
    pcount = 0; pidx = -1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (pulse[0]) begin pcount++; pidx = i; end
    end
    chk("t6_pulse_count", 32'(pcount), 32'(1));
    chk("t6_pulse_cycle", 32'(pidx), 32'(SYNC));

    // random traffic
    do_reset();
    mode = $urandom;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 2) == 0) sig = NUM_CH'($urandom);
      if ($urandom_range(0, 49) == 0) mode = 8'($urandom);
      ready = 1'($urandom_range(0, 1));
      clr   = ($urandom_range(0, 7) == 0) ? NUM_CH'($urandom) : '0;
      rst   = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
